// File: rtl/writeback_arbiter.sv
// Writeback arbiter: pipeline result select plus long-latency result FIFO and pending-destination scoreboard.
// Optional same-cycle bypass of long-latency results into an empty FIFO slot: define WB_BYPASS_EN.
module writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW_in,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic            lu_issue,
    input  logic [4:0]      lu_issue_rd,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            reg_we,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] rd_wdata,
    output logic [31:0]     pend_mask
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]      fifo_rd_d   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pend_q, pend_d;

    logic            pipe_win_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            push_s;
    logic            pop_s;
    logic            bypass_s;
    logic [XLEN-1:0] pipe_data_s;

    // Handshake and arbitration qualifiers
    always_comb begin
        pipe_win_s   = RegWriteW && (RdW_in != 5'd0);
        fifo_empty_s = (count_q == {CNT_W{1'b0}});
        fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
        lu_ready     = !fifo_full_s;
        pop_s        = !rst && !pipe_win_s && !fifo_empty_s;
`ifdef WB_BYPASS_EN
        bypass_s     = !rst && !pipe_win_s && fifo_empty_s && lu_valid && (lu_rd != 5'd0);
`else
        bypass_s     = 1'b0;
`endif
        // x0 results are accepted by the handshake but never stored
        push_s       = lu_valid && !fifo_full_s && (lu_rd != 5'd0) && !bypass_s;
    end

    // Pipeline result select
    always_comb begin
        case (ResultSrcW)
            2'b00:   pipe_data_s = ALUResultW;
            2'b01:   pipe_data_s = ReadDataW;
            2'b10:   pipe_data_s = PCPlus4W;
            default: pipe_data_s = ALUResultW;
        endcase
    end

    // Regfile write port: pipeline first, then FIFO head, then optional bypass
    always_comb begin
        reg_we   = 1'b0;
        RdW      = 5'd0;
        rd_wdata = {XLEN{1'b0}};
        if (rst) begin
            reg_we = 1'b0;
        end else if (pipe_win_s) begin
            reg_we   = 1'b1;
            RdW      = RdW_in;
            rd_wdata = pipe_data_s;
        end else if (pop_s) begin
            reg_we   = 1'b1;
            RdW      = fifo_rd_q[rd_ptr_q];
            rd_wdata = fifo_data_q[rd_ptr_q];
        end else if (bypass_s) begin
            reg_we   = 1'b1;
            RdW      = lu_rd;
            rd_wdata = lu_data;
        end else begin
            reg_we = 1'b0;
        end
    end

    // FIFO and scoreboard next state
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pend_d      = pend_q;
        if (push_s) begin
            fifo_rd_d[wr_ptr_q]   = lu_rd;
            fifo_data_d[wr_ptr_q] = lu_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d                    = rd_ptr_q + PTR_W'(1);
            pend_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (bypass_s) begin
            pend_d[lu_rd] = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Applied last so a same-cycle issue overrides any clear
        if (lu_issue && (lu_issue_rd != 5'd0)) begin
            pend_d[lu_issue_rd] = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= {XLEN{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            pend_q   <= 32'd0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
        end
    end

    assign pend_mask = pend_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (default build, bypass disabled).
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW_in;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        reg_we;
    logic [4:0]  RdW;
    logic [31:0] rd_wdata;
    logic [31:0] pend_mask;

    int vectors;
    int miscompares;

    writeback_arbiter #(.XLEN(32), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .RdW_in     (RdW_in),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .lu_issue   (lu_issue),
        .lu_issue_rd(lu_issue_rd),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .reg_we     (reg_we),
        .RdW        (RdW),
        .rd_wdata   (rd_wdata),
        .pend_mask  (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        #1;
        chk({tag, ".we"}, {31'd0, reg_we}, {31'd0, we});
        chk({tag, ".rd"}, {27'd0, RdW}, {27'd0, rd});
        chk({tag, ".data"}, rd_wdata, data);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; RegWriteW = 1'b1; RdW_in = 5'd5; ResultSrcW = 2'b00;
        ALUResultW = 32'h1111_1111; ReadDataW = 32'hDEAD_BEEF; PCPlus4W = 32'h0000_1004;
        lu_issue = 1'b0; lu_issue_rd = 5'd0; lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;

        // Reset state, pipeline request masked during reset
        tick(); tick();
        chk_wr("rst_out", 1'b0, 5'd0, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_ready", {31'd0, lu_ready}, 32'd1);

        // Result mux, zero latency
        tick(); rst = 1'b0; ResultSrcW = 2'b01;
        chk_wr("mux_load", 1'b1, 5'd5, 32'hDEAD_BEEF);
        ResultSrcW = 2'b00;
        chk_wr("mux_alu", 1'b1, 5'd5, 32'h1111_1111);
        ResultSrcW = 2'b10;
        chk_wr("mux_pc4", 1'b1, 5'd5, 32'h0000_1004);
        ResultSrcW = 2'b11;
        chk_wr("mux_alu11", 1'b1, 5'd5, 32'h1111_1111);

        // Pipeline priority over FIFO drain
        tick(); RdW_in = 5'd3; ResultSrcW = 2'b00;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_1234;
        chk_wr("prio_c0", 1'b1, 5'd3, 32'h1111_1111);
        tick(); lu_valid = 1'b0;
        chk_wr("prio_c1", 1'b1, 5'd3, 32'h1111_1111);
        tick();
        chk_wr("prio_c2", 1'b1, 5'd3, 32'h1111_1111);
        tick(); RegWriteW = 1'b0;
        chk_wr("drain_x7", 1'b1, 5'd7, 32'h0000_1234);
        tick();
        chk_wr("drain_empty", 1'b0, 5'd0, 32'd0);

        // Scoreboard set, clear on pop, set-wins
        tick(); lu_issue = 1'b1; lu_issue_rd = 5'd9;
        #1 chk("sb_before", pend_mask, 32'd0);
        tick(); lu_issue = 1'b0;
        chk("sb_set", pend_mask, 32'h0000_0200);
        RegWriteW = 1'b1; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_0099;
        tick(); lu_valid = 1'b0; RegWriteW = 1'b0;
        chk_wr("sb_pop9", 1'b1, 5'd9, 32'h0000_0099);
        chk("sb_hold", pend_mask, 32'h0000_0200);
        tick();
        chk("sb_clear", pend_mask, 32'd0);
        RegWriteW = 1'b1; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_009A;
        tick(); lu_valid = 1'b0; RegWriteW = 1'b0; lu_issue = 1'b1; lu_issue_rd = 5'd9;
        chk_wr("sb_pop9b", 1'b1, 5'd9, 32'h0000_009A);
        tick(); lu_issue = 1'b0;
        chk("sb_setwins", pend_mask, 32'h0000_0200);
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_009B;
        tick(); lu_valid = 1'b0;
        chk_wr("sb_nobypass", 1'b1, 5'd9, 32'h0000_009B);
        tick();
        chk("sb_clear2", pend_mask, 32'd0);

        // Fill FIFO under a busy pipeline, then backpressure
        RegWriteW = 1'b1; RdW_in = 5'd3;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 32'h0000_00A0 + 32'(i);
            #1 chk("fill_ready", {31'd0, lu_ready}, 32'd1);
            tick();
        end
        lu_rd = 5'd14; lu_data = 32'h0000_00A4;
        #1 chk("full_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        chk("full_hold", {31'd0, lu_ready}, 32'd0);
        RegWriteW = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_wr("drain_order", 1'b1, 5'(10 + i), 32'h0000_00A0 + 32'(i));
            if (i == 0) chk("drain_ready0", {31'd0, lu_ready}, 32'd0);
            if (i == 1) chk("drain_ready1", {31'd0, lu_ready}, 32'd1);
            tick();
            if (i == 1) lu_valid = 1'b0;
        end
        chk_wr("drain_done", 1'b0, 5'd0, 32'd0);

        // x0 pipeline write frees the slot; x0 long-latency result discarded
        tick(); RegWriteW = 1'b1; RdW_in = 5'd3; lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h0000_0044;
        tick(); lu_valid = 1'b0; RdW_in = 5'd0;
        chk_wr("x0_slot", 1'b1, 5'd4, 32'h0000_0044);
        tick(); RegWriteW = 1'b0; lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h0000_0055;
        chk_wr("x0_push_cyc", 1'b0, 5'd0, 32'd0);
        chk("x0_ready", {31'd0, lu_ready}, 32'd1);
        tick(); lu_valid = 1'b0;
        chk_wr("x0_not_stored", 1'b0, 5'd0, 32'd0);

        // Reset mid-operation
        RegWriteW = 1'b1; RdW_in = 5'd3;
        for (int i = 0; i < 4; i++) begin
            lu_issue = 1'b1; lu_issue_rd = 5'(4 + i);
            lu_valid = (i < 3); lu_rd = 5'(20 + i); lu_data = 32'h0000_0C00 + 32'(i);
            tick();
        end
        lu_issue = 1'b0; lu_valid = 1'b0;
        #1 chk("pre_rst_pend", pend_mask, 32'h0000_00F0);
        rst = 1'b1;
        chk_wr("in_rst", 1'b0, 5'd0, 32'd0);
        tick(); rst = 1'b0; RegWriteW = 1'b0;
        chk("post_rst_pend", pend_mask, 32'd0);
        chk_wr("post_rst_c0", 1'b0, 5'd0, 32'd0);
        chk("post_rst_ready", {31'd0, lu_ready}, 32'd1);
        tick();
        chk_wr("post_rst_c1", 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback-end counterpart of the decode stage's register-file write port.
- Produces the regfile write triple reg_we / RdW / rd_wdata consumed by decode.
- Selects the in-order pipeline result (ALU / load / PC+4) and merges results from a long-latency unit (divider, FP) through a small FIFO.
- Keeps a pending-destination scoreboard for the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- FIFO_DEPTH, 4, long-latency result FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- RegWriteW  input  1  pipeline writeback enable.
- RdW_in  input  5  pipeline destination register.
- ResultSrcW  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- ALUResultW  input  XLEN  ALU result.
- ReadDataW  input  XLEN  load data.
- PCPlus4W  input  XLEN  link value.
- lu_issue  input  1  long-latency op issued this cycle.
- lu_issue_rd  input  5  destination of the issued op.
- lu_valid  input  1  long-latency result valid.
- lu_rd  input  5  result destination.
- lu_data  input  XLEN  result data.
- lu_ready  output  1  FIFO can accept (= !full).
- reg_we  output  1  regfile write enable to decode.
- RdW  output  5  regfile write address.
- rd_wdata  output  XLEN  regfile write data.
- pend_mask  output  32  bit i set = xi awaiting a long-latency result.

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO empty; rd/wr pointers and count = 0.
  - pend_mask = 0.
  - While rst=1, reg_we forced 0; RdW = 0; rd_wdata = 0.
- Pipeline select:
  - pipe_win = RegWriteW && RdW_in != 0.
  - When pipe_win: reg_we = 1, RdW = RdW_in, rd_wdata = mux(ResultSrcW).
  - Combinational, zero latency.
- FIFO drain:
  - When !pipe_win and FIFO not empty: reg_we = 1, RdW = head.rd, rd_wdata = head.data.
  - Pop at the clock edge.
  - Pipeline always has priority; FIFO drains only in idle writeback slots.
- RegWriteW=1 with RdW_in=0: treated as no pipeline write, so the slot is free for FIFO drain.
- Push:
  - Occurs on lu_valid && lu_ready.
  - Entries with lu_rd=0 are accepted and discarded (not stored, no write).
- Handshake:
  - lu_ready = !full (count < FIFO_DEPTH).
  - lu_valid while full is not a transfer; the long-latency unit must hold its data.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping mod FIFO_DEPTH.
- Latency: a pushed entry is writable no earlier than the next cycle (without WB_BYPASS_EN).
- Scoreboard:
  - lu_issue && lu_issue_rd != 0 sets pend_mask[lu_issue_rd] at the edge.
  - A FIFO pop writing rd clears pend_mask[rd].
  - Set and clear of the same bit in one cycle: set wins.
  - Pipeline writes never modify pend_mask (WAW ordering is the hazard unit's responsibility).
- No result is dropped except x0 destinations.
- rst asserted mid-operation discards FIFO contents and pending bits.

Optional Feature:
- WB_BYPASS_EN defined:
  - When !pipe_win, FIFO empty and lu_valid with lu_rd != 0, the result is written directly that cycle (reg_we=1, RdW=lu_rd, rd_wdata=lu_data).
  - The entry is not stored, and pend_mask[lu_rd] is cleared at the edge.
- WB_BYPASS_EN undefined:
  - Every long-latency result passes through the FIFO; minimum one-cycle added latency.

Test Plan:
- Mux select: ResultSrcW=01, RegWriteW=1, RdW_in=5, ReadDataW=0xDEADBEEF → same cycle reg_we=1, RdW=5, rd_wdata=0xDEADBEEF. Repeat with 00 and 10 → ALU and PC+4 values respectively.
- Priority/drain:
  - Push lu_rd=7, data 0x1234 while the pipeline writes x3 for 3 cycles → x7 is not written during those cycles.
  - First idle cycle → reg_we=1, RdW=7, rd_wdata=0x1234.
  - Next cycle FIFO is empty.
- Full/backpressure:
  - With the pipeline writing continuously, push 4 results → lu_ready=0.
  - A 5th lu_valid is held; then idle the pipeline → 4 in-order writes, after which the 5th is accepted.
- Scoreboard:
  - lu_issue rd=9 → pend_mask=0x200 next cycle.
  - Result for x9 drains → bit clears after the pop edge.
  - Issue rd=9 in the same cycle as the x9 pop → bit stays 1.
- x0 handling: RegWriteW=1, RdW_in=0 with FIFO holding x4 → reg_we=1, RdW=4. lu_rd=0 push → no write, count unchanged.
- Reset mid-operation: FIFO holding 3 entries, pend_mask=0x0F0, assert rst 1 cycle → count 0, pend_mask 0, reg_we=0 during rst. No stale writes afterwards.
